riscv_branch_hazard_ctrl: RTL and testbench
===========================================

# riscv_branch_hazard_ctrl

Pipeline control block for the five-stage RV32I core, placed beside the ID/EX/MEM pipeline registers. It resolves all six conditional branches plus JAL/JALR in EX and selects the PC source. It drives IF/ID and ID/EX flushes, detects load-use hazards and stalls IF/ID. It keeps saturating performance counters and, optionally, a 2-bit branch history table for static-free prediction.

## Interface
- `BHT_ENTRIES`, 16: BHT depth; power of two, at least 2.
- `CNT_W`, 32: performance counter width.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `exValid` in 1: EX holds a real (non-bubble) instruction.
- `exOpcode` in 7: opcode in EX.
- `exFunc3` in 3: func3 in EX.
- `zero`, `lessThan`, `lessThanU` in 1 each: ALU flags for EX (equal, signed <, unsigned <).
- `exPredTaken` in 1: prediction carried down the pipeline with the EX instruction.
- `exBhtIdx` in $clog2(BHT_ENTRIES): BHT index (PC[n+1:2]) of the EX instruction.
- `ifBhtIdx` in $clog2(BHT_ENTRIES): BHT index of the fetch PC.
- `exMemRead` in 1: EX instruction is a load.
- `exRd` in 5: EX destination register.
- `idRs1`, `idRs2` in 5 each: ID source registers.
- `idUseRs1`, `idUseRs2` in 1 each: the ID instruction actually reads that source.
- `perfClr` in 1: synchronous clear of all counters.
- `pcSrc` out 2: 00 PC+4 / predicted, 01 branch/JAL target, 10 JALR target, 11 EX PC+4 (fall-through correction).
- `flushIfId`, `flushIdEx` out 1: squash those pipeline registers at the next edge.
- `stall` out 1: hold PC and IF/ID and insert a bubble into ID/EX.
- `ifPredTaken` out 1: prediction for the fetch PC.
- `branchCnt`, `mispredCnt`, `stallCnt` out CNT_W: performance counters.

## Operation
- Taken is computed only for opcode 1100011 with exValid. BEQ 000 uses zero. BNE 001 uses !zero. BLT 100 uses lessThan. BGE 101 uses !lessThan. BLTU 110 uses lessThanU. BGEU 111 uses !lessThanU. Func3 010/011 are never taken and never counted.
- JAL (1101111) with exValid gives pcSrc=01. JALR (1100111) with exValid gives pcSrc=10. Both always redirect.
- A branch gives pcSrc=01 when taken && !exPredTaken, pcSrc=11 when !taken && exPredTaken, and 00 otherwise.
- Mispredict is any redirect (pcSrc!=00). flushIfId = flushIdEx = mispredict.
- Load-use: stall = exValid && exMemRead && exRd!=0 && ((idUseRs1 && idRs1==exRd) || (idUseRs2 && idRs2==exRd)).
- Priority: a redirect forces stall=0, because the ID instruction is wrong-path. The stall condition clears naturally after one cycle as the load leaves EX.
- Counters:
  - branchCnt increments on each valid conditional branch in EX.
  - mispredCnt increments on each redirect, including JAL/JALR.
  - stallCnt increments on each stall cycle.
  - All counters saturate at 2^CNT_W-1. perfClr takes priority over increment.

## Timing
- pcSrc, flushes, stall and ifPredTaken are combinational in the same cycle as their inputs. There are no registered outputs except the counters.
- A BHT update for a branch resolved in cycle N becomes visible to ifPredTaken in cycle N+1. A same-cycle read of the index being written returns the old value, with no bypass.
- Counters update at the rising edge ending the event cycle and are visible the next cycle.
- Reset:
  - Counters go to 0.
  - BHT entries go to 01 (weakly not-taken).
  - Combinational outputs follow their inputs. With exValid=0, pcSrc=00, flushes=0 and stall=0.
- Reset asserted mid-operation clears the BHT and counters immediately. No partial update is retained.

## Configuration
- `RISCV_BHT_EN` defined:
  - The BHT is instantiated.
  - ifPredTaken = MSB of entry[ifBhtIdx].
  - Each valid conditional branch updates entry[exBhtIdx] as a 2-bit saturating counter: +1 if taken (cap 11), -1 if not taken (cap 00).
- Undefined:
  - No BHT storage.
  - ifPredTaken=0 and exPredTaken is ignored (treated as 0).
  - pcSrc=11 never occurs; every taken branch redirects via 01.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants: BRANCH, JAL, JALR, LOAD.
  - Branch func3 codes.
  - The pcSrc encoding localparams.
- Natural sub-module: `riscv_bht`. It has parameter BHT_ENTRIES, one combinational read port, one write port (index, taken, valid) and asynchronous reset. It is instantiated only under RISCV_BHT_EN.

## Test plan
- BGEU with lessThanU=0, exPredTaken=0, exValid=1 -> pcSrc=01, both flushes=1, branchCnt+1, mispredCnt+1. BGE with zero=0 and lessThan=0 gives the same result, which proves 101 no longer uses zero.
- Load exRd=5, idRs2=5, idUseRs2=1 -> stall=1 for one cycle, stallCnt=1. Repeat with exRd=0 or idUseRs2=0 -> stall=0.
- Load-use hazard in the same cycle as a JALR in EX -> pcSrc=10, flushes=1, stall=0, stallCnt unchanged.
- With RISCV_BHT_EN: two taken branches at idx 3 -> entry 01→10→11, ifPredTaken=1 for idx 3 from the cycle after the first update. Then a not-taken branch with exPredTaken=1 -> pcSrc=11 and entry 10.
- With CNT_W=4: 20 stall cycles -> stallCnt holds 15. perfClr with a simultaneous stall -> stallCnt=0.
- rst_n pulsed low mid-run -> all counters 0 and every BHT entry reads 01 (ifPredTaken=0) on the first cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, branch func3 codes and pcSrc encoding shared by the branch/hazard control slice.
package riscv_pkg;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LOAD   = 7'b0000011;
   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_f3_e;
   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BR   = 2'b01;
   localparam logic [1:0] PC_JALR = 2'b10;
   localparam logic [1:0] PC_FALL = 2'b11;
endpackage

// File: rtl/riscv_branch_hazard_ctrl_if.sv
// riscv_branch_hazard_ctrl_if: pipeline-side signals of the branch/hazard controller; slave is the controller.
interface riscv_branch_hazard_ctrl_if #(
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 32
);
   localparam int IW = $clog2(BHT_ENTRIES);
   logic             exValid;
   logic [6:0]       exOpcode;
   logic [2:0]       exFunc3;
   logic             zero, lessThan, lessThanU;
   logic             exPredTaken;
   logic [IW-1:0]    exBhtIdx, ifBhtIdx;
   logic             exMemRead;
   logic [4:0]       exRd, idRs1, idRs2;
   logic             idUseRs1, idUseRs2;
   logic             perfClr;
   logic [1:0]       pcSrc;
   logic             flushIfId, flushIdEx, stall, ifPredTaken;
   logic [CNT_W-1:0] branchCnt, mispredCnt, stallCnt;
   modport master (
      output exValid, exOpcode, exFunc3, zero, lessThan, lessThanU, exPredTaken, exBhtIdx, ifBhtIdx,
             exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2, perfClr,
      input  pcSrc, flushIfId, flushIdEx, stall, ifPredTaken, branchCnt, mispredCnt, stallCnt
   );
   modport slave (
      input  exValid, exOpcode, exFunc3, zero, lessThan, lessThanU, exPredTaken, exBhtIdx, ifBhtIdx,
             exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2, perfClr,
      output pcSrc, flushIfId, flushIdEx, stall, ifPredTaken, branchCnt, mispredCnt, stallCnt
   );
endinterface

// File: rtl/riscv_bht.sv
// riscv_bht: table of 2-bit saturating branch counters, async read of the MSB, one update port.
module riscv_bht #(
   parameter int BHT_ENTRIES = 16,
   localparam int IW = $clog2(BHT_ENTRIES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] rd_idx,
   output logic          rd_taken,
   input  logic [IW-1:0] wr_idx,
   input  logic          wr_taken,
   input  logic          wr_valid
);
   logic [1:0] tbl [BHT_ENTRIES];
   logic [1:0] cur;
   assign rd_taken = tbl[rd_idx][1];
   assign cur = tbl[wr_idx];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) tbl[i] <= 2'b01;
      end else if (wr_valid) begin
         tbl[wr_idx] <= wr_taken ? ((&cur) ? cur : cur + 2'd1) : ((|cur) ? cur - 2'd1 : cur);
      end
   end
endmodule

// File: rtl/riscv_branch_hazard_ctrl.sv
// riscv_branch_hazard_ctrl: EX branch/jump resolution, flush and load-use stall control, saturating perf counters.
// Defining RISCV_BHT_EN adds a 2-bit branch history table driving ifPredTaken.
module riscv_branch_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input logic clk,
   input logic rst_n,
   riscv_branch_hazard_ctrl_if.slave bus
);
   logic       is_br, cond_br, flag, taken, pred, hazard, redirect;
   logic [1:0] pc_src;
   logic [CNT_W-1:0] br_cnt, mis_cnt, st_cnt;
   always_comb begin
      is_br    = bus.exValid && bus.exOpcode == BRANCH;
      cond_br  = is_br && bus.exFunc3[2:1] != 2'b01;
      // func3[2] picks signed/unsigned less-than over equality, func3[0] inverts the sense
      flag     = bus.exFunc3[2] ? (bus.exFunc3[1] ? bus.lessThanU : bus.lessThan) : bus.zero;
      taken    = cond_br && (flag ^ bus.exFunc3[0]);
      pc_src   = !bus.exValid               ? PC_SEQ  :
                 bus.exOpcode == JAL        ? PC_BR   :
                 bus.exOpcode == JALR       ? PC_JALR :
                 !is_br                     ? PC_SEQ  :
                 (taken && !pred)           ? PC_BR   :
                 (!taken && pred)           ? PC_FALL : PC_SEQ;
      redirect = pc_src != PC_SEQ;
      hazard   = bus.exValid && bus.exMemRead && bus.exRd != 5'd0 &&
                 ((bus.idUseRs1 && bus.idRs1 == bus.exRd) || (bus.idUseRs2 && bus.idRs2 == bus.exRd));
   end
   assign bus.pcSrc     = pc_src;
   assign bus.flushIfId = redirect;
   assign bus.flushIdEx = redirect;
   assign bus.stall     = hazard && !redirect;
`ifdef RISCV_BHT_EN
   assign pred = bus.exPredTaken;
   riscv_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (bus.ifBhtIdx),
      .rd_taken (bus.ifPredTaken),
      .wr_idx   (bus.exBhtIdx),
      .wr_taken (taken),
      .wr_valid (cond_br)
   );
`else
   logic unused_bht;
   assign pred = 1'b0;
   assign bus.ifPredTaken = 1'b0;
   assign unused_bht = ^{bus.exPredTaken, bus.exBhtIdx, bus.ifBhtIdx};
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
         st_cnt  <= '0;
      end else if (bus.perfClr) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
         st_cnt  <= '0;
      end else begin
         if (cond_br && !(&br_cnt)) br_cnt <= br_cnt + 1'b1;
         if (redirect && !(&mis_cnt)) mis_cnt <= mis_cnt + 1'b1;
         if (bus.stall && !(&st_cnt)) st_cnt <= st_cnt + 1'b1;
      end
   end
   assign bus.branchCnt  = br_cnt;
   assign bus.mispredCnt = mis_cnt;
   assign bus.stallCnt   = st_cnt;
endmodule

// File: tb/tb_riscv_branch_hazard_ctrl.sv
// tb_riscv_branch_hazard_ctrl: vector table, directed corner sequences and random traffic against a behavioural model.
module tb_riscv_branch_hazard_ctrl;
   import riscv_pkg::*;
   localparam int N = 16;
   localparam int W = 4;
   localparam int CMAX = (1 << W) - 1;
   localparam logic [6:0] ALU = 7'b0110011;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   riscv_branch_hazard_ctrl_if #(.BHT_ENTRIES(N), .CNT_W(W)) bus ();
   riscv_branch_hazard_ctrl #(.BHT_ENTRIES(N), .CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int m_br, m_mis, m_st;
   int m_bht [N];

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       z, lt, ltu, mr;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2;
      int         e_pc;
      int         e_st;
   } vec_t;
   vec_t vt [16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_taken();
      case (bus.exFunc3)
         3'b000: return int'(bus.zero);
         3'b001: return int'(!bus.zero);
         3'b100: return int'(bus.lessThan);
         3'b101: return int'(!bus.lessThan);
         3'b110: return int'(bus.lessThanU);
         3'b111: return int'(!bus.lessThanU);
         default: return 0;
      endcase
   endfunction

   function automatic int m_cond();
      return int'(bus.exValid && bus.exOpcode == BRANCH && bus.exFunc3 != 3'b010 && bus.exFunc3 != 3'b011);
   endfunction

   function automatic int m_pcsrc();
      int t, p;
      if (!bus.exValid) return 0;
      if (bus.exOpcode == JAL) return 1;
      if (bus.exOpcode == JALR) return 2;
      if (bus.exOpcode != BRANCH) return 0;
      t = m_taken();
`ifdef RISCV_BHT_EN
      p = int'(bus.exPredTaken);
`else
      p = 0;
`endif
      if (t == p) return 0;
      return t ? 1 : 3;
   endfunction

   function automatic int m_stall();
      bit h;
      h = bus.exValid && bus.exMemRead && bus.exRd != 0 &&
          ((bus.idUseRs1 && bus.idRs1 == bus.exRd) || (bus.idUseRs2 && bus.idRs2 == bus.exRd));
      return int'(h && m_pcsrc() == 0);
   endfunction

   function automatic int m_ifpred();
`ifdef RISCV_BHT_EN
      return int'(m_bht[bus.ifBhtIdx] >= 2);
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_br = 0; m_mis = 0; m_st = 0;
      for (int i = 0; i < N; i++) m_bht[i] = 1;
   endtask

   task automatic idle();
      bus.exValid = 0; bus.exOpcode = 0; bus.exFunc3 = 0; bus.zero = 0; bus.lessThan = 0; bus.lessThanU = 0;
      bus.exPredTaken = 0; bus.exBhtIdx = 0; bus.ifBhtIdx = 0; bus.exMemRead = 0; bus.exRd = 0;
      bus.idRs1 = 0; bus.idRs2 = 0; bus.idUseRs1 = 0; bus.idUseRs2 = 0; bus.perfClr = 0;
   endtask

   task automatic apply_vec(input vec_t v);
      bus.exValid = 1; bus.exOpcode = v.op; bus.exFunc3 = v.f3; bus.zero = v.z; bus.lessThan = v.lt;
      bus.lessThanU = v.ltu; bus.exPredTaken = 0; bus.exMemRead = v.mr; bus.exRd = v.rd;
      bus.idRs1 = v.rs1; bus.idRs2 = v.rs2; bus.idUseRs1 = v.u1; bus.idUseRs2 = v.u2;
   endtask

   task automatic check_outputs();
      int p;
      p = m_pcsrc();
      chk("pcSrc", int'(bus.pcSrc), p);
      chk("flushIfId", int'(bus.flushIfId), int'(p != 0));
      chk("flushIdEx", int'(bus.flushIdEx), int'(p != 0));
      chk("stall", int'(bus.stall), m_stall());
      chk("ifPredTaken", int'(bus.ifPredTaken), m_ifpred());
      chk("branchCnt", int'(bus.branchCnt), m_br);
      chk("mispredCnt", int'(bus.mispredCnt), m_mis);
      chk("stallCnt", int'(bus.stallCnt), m_st);
   endtask

   // Captures the event cycle's effects before the edge, commits them after it.
   task automatic edge_step();
      int c, mis, st, t, idx, clr;
      c = m_cond(); mis = int'(m_pcsrc() != 0); st = m_stall(); t = m_taken();
      idx = int'(bus.exBhtIdx); clr = int'(bus.perfClr);
      @(posedge clk);
      if (clr) begin
         m_br = 0; m_mis = 0; m_st = 0;
      end else begin
         if (c && m_br < CMAX) m_br++;
         if (mis && m_mis < CMAX) m_mis++;
         if (st && m_st < CMAX) m_st++;
      end
      if (c) m_bht[idx] = t ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3) : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
      #1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      edge_step();
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      check_outputs();
      #2 rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      int r;
      r = $urandom_range(0, 9);
      bus.exValid = $urandom_range(0, 7) != 0;
      bus.exOpcode = r < 5 ? BRANCH : r == 5 ? JAL : r == 6 ? JALR : r < 9 ? LOAD : ALU;
      bus.exFunc3 = 3'($urandom);
      bus.zero = 1'($urandom); bus.lessThan = 1'($urandom); bus.lessThanU = 1'($urandom);
      bus.exPredTaken = 1'($urandom);
      bus.exBhtIdx = 4'($urandom); bus.ifBhtIdx = 4'($urandom);
      bus.exMemRead = (r >= 7 && r < 9) || $urandom_range(0, 15) == 0;
      bus.exRd = 5'($urandom_range(0, 3)); bus.idRs1 = 5'($urandom_range(0, 3)); bus.idRs2 = 5'($urandom_range(0, 3));
      bus.idUseRs1 = 1'($urandom); bus.idUseRs2 = 1'($urandom);
      bus.perfClr = $urandom_range(0, 29) == 0;
   endtask

   initial begin
      vt[0]  = '{BRANCH, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vt[1]  = '{BRANCH, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vt[2]  = '{BRANCH, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vt[3]  = '{BRANCH, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[4]  = '{BRANCH, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[5]  = '{BRANCH, 3'b100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vt[6]  = '{BRANCH, 3'b110, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[7]  = '{BRANCH, 3'b010, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[8]  = '{JAL,    3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vt[9]  = '{JALR,   3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
      vt[10] = '{LOAD,   3'b010, 0, 0, 0, 1, 5, 0, 5, 0, 1, 0, 1};
      vt[11] = '{LOAD,   3'b010, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
      vt[12] = '{LOAD,   3'b010, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0, 0};
      vt[13] = '{LOAD,   3'b010, 0, 0, 0, 1, 7, 7, 0, 1, 0, 0, 1};
      vt[14] = '{JALR,   3'b000, 0, 0, 0, 1, 5, 0, 5, 0, 1, 2, 0};
      vt[15] = '{ALU,    3'b000, 0, 0, 0, 0, 5, 5, 0, 1, 0, 0, 0};

      idle();
      model_reset();
      #12 rst_n = 1;
      @(posedge clk); #1;
      cycle();
      chk("reset_branchCnt", int'(bus.branchCnt), 0);
      chk("reset_stallCnt", int'(bus.stallCnt), 0);

      apply_vec(vt[0]);
      cycle();
      idle();
      chk("bgeu_branchCnt", int'(bus.branchCnt), 1);
      chk("bgeu_mispredCnt", int'(bus.mispredCnt), 1);

      do_reset();
      apply_vec(vt[10]);
      cycle();
      idle();
      @(negedge clk);
      chk("loaduse_stallCnt", int'(bus.stallCnt), 1);
      chk("loaduse_stall_cleared", int'(bus.stall), 0);
      edge_step();

      for (int i = 0; i < 16; i++) begin
         apply_vec(vt[i]);
         @(negedge clk);
         check_outputs();
         chk($sformatf("vec%0d_pcSrc", i), int'(bus.pcSrc), vt[i].e_pc);
         chk($sformatf("vec%0d_stall", i), int'(bus.stall), vt[i].e_st);
         chk($sformatf("vec%0d_flush", i), int'(bus.flushIdEx), int'(vt[i].e_pc != 0));
         edge_step();
      end

      do_reset();
      apply_vec(vt[10]);
      for (int i = 0; i < 20; i++) cycle();
      chk("sat_stallCnt", int'(bus.stallCnt), 15);
      bus.perfClr = 1;
      cycle();
      bus.perfClr = 0;
      chk("clr_stallCnt", int'(bus.stallCnt), 0);

`ifdef RISCV_BHT_EN
      do_reset();
      apply_vec(vt[2]);
      bus.exBhtIdx = 3; bus.ifBhtIdx = 3;
      @(negedge clk);
      chk("bht_no_bypass", int'(bus.ifPredTaken), 0);
      check_outputs();
      edge_step();
      chk("bht_after_first", int'(bus.ifPredTaken), 1);
      cycle();
      bus.zero = 0; bus.exPredTaken = 1;
      @(negedge clk);
      chk("bht_fallthrough_pcSrc", int'(bus.pcSrc), 3);
      check_outputs();
      edge_step();
      chk("bht_entry10", int'(bus.ifPredTaken), 1);
      cycle();
      chk("bht_entry01", int'(bus.ifPredTaken), 0);
      idle();
`endif

      for (int i = 0; i < 400; i++) begin
         rand_in();
         cycle();
      end

      bus.perfClr = 0;
      for (int i = 0; i < 30; i++) begin
         rand_in();
         bus.perfClr = 0;
         cycle();
      end
      rst_n = 0;
      #1;
      chk("midrst_branchCnt", int'(bus.branchCnt), 0);
      chk("midrst_mispredCnt", int'(bus.mispredCnt), 0);
      chk("midrst_stallCnt", int'(bus.stallCnt), 0);
      model_reset();
      idle();
      @(negedge clk);
      #2 rst_n = 1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         bus.ifBhtIdx = 4'(i);
         @(negedge clk);
         chk($sformatf("midrst_bht%0d", i), int'(bus.ifPredTaken), 0);
         check_outputs();
         edge_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
